// File: rtl/ysyx_041514_pipe_ctrl_if.sv
// Pipeline control bundle: per-stage stall requests, redirect/trap/fence.i
// events, cache-maintenance handshakes and the shared stall/flush buses.
`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 64
`endif

interface ysyx_041514_pipe_ctrl_if;
  logic                          stall_req_if_i;
  logic                          stall_req_ex_i;
  logic                          stall_req_mem_i;
  logic                          redirect_valid_i;
  logic [`ysyx_041514_XLEN-1:0]  redirect_pc_i;
  logic                          trap_valid_i;
  logic [`ysyx_041514_XLEN-1:0]  trap_pc_i;
  logic                          fencei_valid_i;
  logic [`ysyx_041514_XLEN-1:0]  fencei_pc_i;
  logic                          dcache_flush_done_i;
  logic                          icache_inv_done_i;
  logic [5:0]                    stall_valid_o;
  logic [5:0]                    flush_valid_o;
  logic                          pc_redirect_valid_o;
  logic [`ysyx_041514_XLEN-1:0]  pc_redirect_pc_o;
  logic                          dcache_flush_req_o;
  logic                          icache_inv_req_o;
  logic                          busy_o;
  logic [63:0]                   perf_stall_cnt_o;
  logic [63:0]                   perf_flush_cnt_o;

  modport master (
    output stall_req_if_i, stall_req_ex_i, stall_req_mem_i,
    output redirect_valid_i, redirect_pc_i, trap_valid_i, trap_pc_i,
    output fencei_valid_i, fencei_pc_i, dcache_flush_done_i, icache_inv_done_i,
    input  stall_valid_o, flush_valid_o, pc_redirect_valid_o, pc_redirect_pc_o,
    input  dcache_flush_req_o, icache_inv_req_o, busy_o,
    input  perf_stall_cnt_o, perf_flush_cnt_o
  );

  modport slave (
    input  stall_req_if_i, stall_req_ex_i, stall_req_mem_i,
    input  redirect_valid_i, redirect_pc_i, trap_valid_i, trap_pc_i,
    input  fencei_valid_i, fencei_pc_i, dcache_flush_done_i, icache_inv_done_i,
    output stall_valid_o, flush_valid_o, pc_redirect_valid_o, pc_redirect_pc_o,
    output dcache_flush_req_o, icache_inv_req_o, busy_o,
    output perf_stall_cnt_o, perf_flush_cnt_o
  );
endinterface

// File: rtl/ysyx_041514_pipe_ctrl.sv
// Pipeline control unit: stall/flush generation, trap > fence.i > branch
// arbitration, redirect hold and fence.i sequencing. YSYX_041514_CTRL_PERF_EN adds perf counters.
`ifndef ysyx_041514_XLEN
`define ysyx_041514_XLEN 64
`endif

module ysyx_041514_pipe_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_041514_pipe_ctrl_if.slave ctrl
);
  localparam int XLEN = `ysyx_041514_XLEN;
  localparam logic [5:0] FLUSH_LONG  = 6'b011110;
  localparam logic [5:0] FLUSH_SHORT = 6'b001110;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REDIR = 2'd1,
    S_FI_DC = 2'd2,
    S_FI_IC = 2'd3
  } state_e;

  state_e          state_r, state_nxt_s;
  logic [XLEN-1:0] redir_pc_r, redir_pc_nxt_s;
  logic [5:0]      req_stall_s, req_flush_s;
  logic [5:0]      fsm_stall_s, fsm_flush_s;
  logic [5:0]      stall_valid_s, flush_valid_s;

  // Stall request decode: the deepest requesting stage decides the bubble
  always_comb begin
    if (ctrl.stall_req_mem_i) begin
      req_stall_s = 6'b011111;
      req_flush_s = 6'b100000;
    end else if (ctrl.stall_req_ex_i) begin
      req_stall_s = 6'b001111;
      req_flush_s = 6'b010000;
    end else if (ctrl.stall_req_if_i) begin
      req_stall_s = 6'b000011;
      req_flush_s = 6'b000100;
    end else begin
      req_stall_s = 6'b000000;
      req_flush_s = 6'b000000;
    end
  end

  // Event arbitration and next-state; flush bit 0 is never driven here
  always_comb begin
    state_nxt_s    = state_r;
    redir_pc_nxt_s = redir_pc_r;
    fsm_stall_s    = 6'b000000;
    fsm_flush_s    = 6'b000000;
    case (state_r)
      S_IDLE: begin
        if (ctrl.trap_valid_i) begin
          fsm_flush_s    = FLUSH_LONG;
          redir_pc_nxt_s = ctrl.trap_pc_i;
          state_nxt_s    = S_REDIR;
        end else if (ctrl.fencei_valid_i) begin
          fsm_flush_s    = FLUSH_LONG;
          redir_pc_nxt_s = ctrl.fencei_pc_i + 64'd4;
          state_nxt_s    = S_FI_DC;
        end else if (ctrl.redirect_valid_i) begin
          fsm_flush_s    = FLUSH_SHORT;
          redir_pc_nxt_s = ctrl.redirect_pc_i;
          state_nxt_s    = S_REDIR;
        end else begin
          state_nxt_s    = S_IDLE;
        end
      end
      S_REDIR: begin
        // A younger branch cannot displace a pending target; an older trap can
        if (ctrl.trap_valid_i) begin
          fsm_flush_s    = FLUSH_LONG;
          redir_pc_nxt_s = ctrl.trap_pc_i;
        end else if (!req_stall_s[0]) begin
          fsm_flush_s    = FLUSH_SHORT;
          state_nxt_s    = S_IDLE;
        end else begin
          fsm_flush_s    = FLUSH_SHORT;
        end
      end
      S_FI_DC: begin
        fsm_stall_s = 6'b000001;
        fsm_flush_s = FLUSH_LONG;
        if (ctrl.dcache_flush_done_i) begin
          state_nxt_s = S_FI_IC;
        end else begin
          state_nxt_s = S_FI_DC;
        end
      end
      S_FI_IC: begin
        fsm_stall_s = 6'b000001;
        fsm_flush_s = FLUSH_LONG;
        if (ctrl.icache_inv_done_i) begin
          state_nxt_s = S_REDIR;
        end else begin
          state_nxt_s = S_FI_IC;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  assign stall_valid_s = req_stall_s | fsm_stall_s;
  assign flush_valid_s = req_flush_s | fsm_flush_s;

  // FSM state and latched redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      redir_pc_r <= 64'd0;
    end else begin
      state_r    <= state_nxt_s;
      redir_pc_r <= redir_pc_nxt_s;
    end
  end

  // Output drive; everything reads zero while reset is held
  always_comb begin
    if (rst) begin
      ctrl.stall_valid_o       = 6'b000000;
      ctrl.flush_valid_o       = 6'b000000;
      ctrl.pc_redirect_valid_o = 1'b0;
      ctrl.pc_redirect_pc_o    = 64'd0;
      ctrl.dcache_flush_req_o  = 1'b0;
      ctrl.icache_inv_req_o    = 1'b0;
      ctrl.busy_o              = 1'b0;
    end else begin
      ctrl.stall_valid_o       = stall_valid_s;
      ctrl.flush_valid_o       = flush_valid_s;
      ctrl.pc_redirect_valid_o = (state_r == S_REDIR);
      ctrl.pc_redirect_pc_o    = (state_r == S_REDIR) ? redir_pc_r : 64'd0;
      ctrl.dcache_flush_req_o  = (state_r == S_FI_DC);
      ctrl.icache_inv_req_o    = (state_r == S_FI_IC);
      ctrl.busy_o              = (state_r != S_IDLE);
    end
  end

`ifdef YSYX_041514_CTRL_PERF_EN
  logic        accept_s;
  logic [63:0] stall_cnt_r;
  logic [63:0] flush_cnt_r;

  assign accept_s = ((state_r == S_IDLE) &&
                     (ctrl.trap_valid_i || ctrl.fencei_valid_i || ctrl.redirect_valid_i)) ||
                    ((state_r == S_REDIR) && ctrl.trap_valid_i);

  // Stall-cycle and accepted-event counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 64'd0;
      flush_cnt_r <= 64'd0;
    end else begin
      if (stall_valid_s[0]) begin
        stall_cnt_r <= stall_cnt_r + 64'd1;
      end
      if (accept_s) begin
        flush_cnt_r <= flush_cnt_r + 64'd1;
      end
    end
  end

  assign ctrl.perf_stall_cnt_o = rst ? 64'd0 : stall_cnt_r;
  assign ctrl.perf_flush_cnt_o = rst ? 64'd0 : flush_cnt_r;
`else
  assign ctrl.perf_stall_cnt_o = 64'd0;
  assign ctrl.perf_flush_cnt_o = 64'd0;
`endif

endmodule
